// File: rtl/mesi_isc_pkg.sv
// Shared command/breq-type encodings and widths for the MESI ISC broadcast-request path.
package mesi_isc_pkg;

    localparam int MBUS_CMD_W  = 3;
    localparam int BREQ_TYPE_W = 2;

    typedef enum logic [MBUS_CMD_W-1:0] {
        MBUS_CMD_NOP      = 3'd0,
        MBUS_CMD_WR       = 3'd1,
        MBUS_CMD_RD       = 3'd2,
        MBUS_CMD_WR_BROAD = 3'd3,
        MBUS_CMD_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [BREQ_TYPE_W-1:0] {
        BREQ_TYPE_NOP = 2'd0,
        BREQ_TYPE_WR  = 2'd1,
        BREQ_TYPE_RD  = 2'd2
    } breq_type_e;

endpackage

// File: rtl/mesi_isc_rr_arb.sv
// N-way round-robin arbiter; a non-empty priority subset of the requests wins over the rest.
module mesi_isc_rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         prio_mask,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  prio_req_s;
    logic [N-1:0]  eff_req_s;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] idx_s;
    logic          found_s;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    assign prio_req_s = req & prio_mask;
    assign eff_req_s  = (|prio_req_s) ? prio_req_s : req;

    // Search for the first eligible request at or after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && eff_req_s[wrap_idx(ptr_r, k)]) begin
                found_s = 1'b1;
                idx_s   = wrap_idx(ptr_r, k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Drive the one-hot grant only when arbitration is enabled.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = en && found_s;
        if (grant_valid) begin
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
        end else begin
            grant     = '0;
            grant_idx = '0;
        end
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (grant_valid) begin
            ptr_r <= wrap_idx(idx_s, 1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mesi_isc_breq_fifos_cntl_n.sv
// Per-CPU broadcast-request FIFO write control plus round-robin pop into the broadcast FIFO.
// Define MESI_ISC_BREQ_WR_PRIO_EN to let channels whose head is a WR win arbitration first.
module mesi_isc_breq_fifos_cntl_n
    import mesi_isc_pkg::*;
#(
    parameter int CPU_NUM          = 4,
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CPU_NUM*MBUS_CMD_WIDTH-1:0]     mbus_cmd_array_i,
    input  logic [CPU_NUM-1:0]                    fifo_status_empty_array_i,
    input  logic [CPU_NUM-1:0]                    fifo_status_full_array_i,
    input  logic                                  broad_fifo_status_full_i,
    input  logic [CPU_NUM*ADDR_WIDTH-1:0]         broad_addr_array_i,
    input  logic [CPU_NUM*BROAD_TYPE_WIDTH-1:0]   broad_type_array_i,
    input  logic [CPU_NUM*BROAD_ID_WIDTH-1:0]     broad_id_array_i,
    output logic [CPU_NUM-1:0]                    mbus_ack_array_o,
    output logic [CPU_NUM-1:0]                    fifo_wr_array_o,
    output logic [CPU_NUM-1:0]                    fifo_rd_array_o,
    output logic                                  broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]                 broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]           broad_type_o,
    output logic [BROAD_ID_WIDTH-1:0]             broad_id_o,
    output logic [$clog2(CPU_NUM)-1:0]            broad_cpu_id_o,
    output logic [CPU_NUM*BROAD_TYPE_WIDTH-1:0]   breq_type_array_o,
    output logic [CPU_NUM*$clog2(CPU_NUM)-1:0]    breq_cpu_id_array_o,
    output logic [CPU_NUM*BROAD_ID_WIDTH-1:0]     breq_id_array_o
);

    localparam int CW = $clog2(CPU_NUM);

    logic [CPU_NUM-1:0]          accept_s;
    logic [CPU_NUM-1:0]          ack_r;
    logic [CPU_NUM-1:0]          wr_r;
    logic [BROAD_TYPE_WIDTH-1:0] type_r [CPU_NUM];
    logic [BROAD_ID_WIDTH-1:0]   id_r   [CPU_NUM];
    logic [CPU_NUM-1:0]          req_s;
    logic [CPU_NUM-1:0]          prio_s;
    logic [CPU_NUM-1:0]          grant_s;
    logic [CW-1:0]               grant_idx_s;
    logic                        grant_valid_s;
    logic                        arb_en_s;

    function automatic logic is_broad_cmd(input logic [MBUS_CMD_WIDTH-1:0] cmd);
        case (cmd)
            MBUS_CMD_WIDTH'(MBUS_CMD_WR_BROAD): return 1'b1;
            MBUS_CMD_WIDTH'(MBUS_CMD_RD_BROAD): return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [BROAD_TYPE_WIDTH-1:0] breq_type_of(input logic [MBUS_CMD_WIDTH-1:0] cmd);
        case (cmd)
            MBUS_CMD_WIDTH'(MBUS_CMD_RD_BROAD): return BROAD_TYPE_WIDTH'(BREQ_TYPE_RD);
            MBUS_CMD_WIDTH'(MBUS_CMD_WR_BROAD): return BROAD_TYPE_WIDTH'(BREQ_TYPE_WR);
            default:                            return BROAD_TYPE_WIDTH'(BREQ_TYPE_NOP);
        endcase
    endfunction

    // A held broadcast command is refused in the ack cycle, giving one ack every other cycle.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            accept_s[i] = is_broad_cmd(mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH])
                          && !fifo_status_full_array_i[i] && !ack_r[i];
        end
    end

    // Channel-side registers: ack/write strobes, written type, and the per-channel id sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r <= '0;
            wr_r  <= '0;
            for (int i = 0; i < CPU_NUM; i++) begin
                type_r[i] <= '0;
                id_r[i]   <= BROAD_ID_WIDTH'(i);
            end
        end else begin
            ack_r <= accept_s;
            wr_r  <= accept_s;
            for (int i = 0; i < CPU_NUM; i++) begin
                type_r[i] <= breq_type_of(mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]);
                if (wr_r[i]) begin
                    id_r[i] <= id_r[i] + BROAD_ID_WIDTH'(CPU_NUM);
                end else begin
                    id_r[i] <= id_r[i];
                end
            end
        end
    end

    assign req_s    = ~fifo_status_empty_array_i;
    assign arb_en_s = !rst && !broad_fifo_status_full_i;

`ifdef MESI_ISC_BREQ_WR_PRIO_EN
    // Channels presenting a WR at the FIFO head form the preferred set.
    always_comb begin
        prio_s = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            prio_s[i] = (broad_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH]
                         == BROAD_TYPE_WIDTH'(BREQ_TYPE_WR));
        end
    end
`else
    assign prio_s = '1;
`endif

    mesi_isc_rr_arb #(
        .N (CPU_NUM)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (arb_en_s),
        .req         (req_s),
        .prio_mask   (prio_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // One-hot select of the granted head; all-zero when nothing is granted.
    always_comb begin
        broad_addr_o = '0;
        broad_type_o = '0;
        broad_id_o   = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            if (grant_s[i]) begin
                broad_addr_o = broad_addr_o | broad_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                broad_type_o = broad_type_o | broad_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
                broad_id_o   = broad_id_o   | broad_id_array_i[i*BROAD_ID_WIDTH +: BROAD_ID_WIDTH];
            end else begin
                broad_addr_o = broad_addr_o;
                broad_type_o = broad_type_o;
                broad_id_o   = broad_id_o;
            end
        end
    end

    assign mbus_ack_array_o = ack_r;
    assign fifo_wr_array_o  = wr_r;
    assign fifo_rd_array_o  = grant_s;
    assign broad_fifo_wr_o  = grant_valid_s;
    assign broad_cpu_id_o   = grant_idx_s;

    for (genvar g = 0; g < CPU_NUM; g++) begin : g_chan_out
        assign breq_type_array_o[g*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] = type_r[g];
        assign breq_id_array_o[g*BROAD_ID_WIDTH +: BROAD_ID_WIDTH]       = id_r[g];
        assign breq_cpu_id_array_o[g*CW +: CW]                           = CW'(g);
    end

endmodule

// File: tb/tb_mesi_isc_breq_fifos_cntl_n.sv
// Scoreboard bench: a cycle-level reference model queues expected acks/grants, a monitor checks them.
module tb_mesi_isc_breq_fifos_cntl_n;

    localparam int N    = 4;
    localparam int CMDW = 3;
    localparam int AW   = 32;
    localparam int TW   = 2;
    localparam int IDW  = 7;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*CMDW-1:0] mbus_cmd_array_i;
    logic [N-1:0]      fifo_status_empty_array_i;
    logic [N-1:0]      fifo_status_full_array_i;
    logic              broad_fifo_status_full_i;
    logic [N*AW-1:0]   broad_addr_array_i;
    logic [N*TW-1:0]   broad_type_array_i;
    logic [N*IDW-1:0]  broad_id_array_i;
    logic [N-1:0]      mbus_ack_array_o;
    logic [N-1:0]      fifo_wr_array_o;
    logic [N-1:0]      fifo_rd_array_o;
    logic              broad_fifo_wr_o;
    logic [AW-1:0]     broad_addr_o;
    logic [TW-1:0]     broad_type_o;
    logic [IDW-1:0]    broad_id_o;
    logic [CW-1:0]     broad_cpu_id_o;
    logic [N*TW-1:0]   breq_type_array_o;
    logic [N*CW-1:0]   breq_cpu_id_array_o;
    logic [N*IDW-1:0]  breq_id_array_o;

    mesi_isc_breq_fifos_cntl_n dut (
        .clk                       (clk),
        .rst                       (rst),
        .mbus_cmd_array_i          (mbus_cmd_array_i),
        .fifo_status_empty_array_i (fifo_status_empty_array_i),
        .fifo_status_full_array_i  (fifo_status_full_array_i),
        .broad_fifo_status_full_i  (broad_fifo_status_full_i),
        .broad_addr_array_i        (broad_addr_array_i),
        .broad_type_array_i        (broad_type_array_i),
        .broad_id_array_i          (broad_id_array_i),
        .mbus_ack_array_o          (mbus_ack_array_o),
        .fifo_wr_array_o           (fifo_wr_array_o),
        .fifo_rd_array_o           (fifo_rd_array_o),
        .broad_fifo_wr_o           (broad_fifo_wr_o),
        .broad_addr_o              (broad_addr_o),
        .broad_type_o              (broad_type_o),
        .broad_id_o                (broad_id_o),
        .broad_cpu_id_o            (broad_cpu_id_o),
        .breq_type_array_o         (breq_type_array_o),
        .breq_cpu_id_array_o       (breq_cpu_id_array_o),
        .breq_id_array_o           (breq_id_array_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int            cyc;
        logic [N-1:0]  vec;
        logic [N*TW-1:0]  typ;
        logic [N*IDW-1:0] ids;
    } ack_exp_t;

    typedef struct packed {
        int            cyc;
        logic [N-1:0]  rd;
        logic [CW-1:0] cid;
        logic [AW-1:0] addr;
        logic [TW-1:0] typ;
        logic [IDW-1:0] id;
    } gnt_exp_t;

    ack_exp_t ackq[$];
    gnt_exp_t gntq[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // stimulus for the current cycle
    bit            t_rst;
    int            t_cmd  [N];
    logic [N-1:0]  t_full;
    logic [N-1:0]  t_empty;
    bit            t_bfull;
    logic [AW-1:0] t_addr [N];
    int            t_type [N];
    logic [IDW-1:0] t_id  [N];

    // reference model state
    int           p_m = 0;
    logic [N-1:0] ack_m = '0;
    int           id_m [N];

    function automatic int pick_channel();
        logic [N-1:0] cand;
        logic [N-1:0] wr_heads;
        cand = ~t_empty;
        wr_heads = '0;
        for (int i = 0; i < N; i++) wr_heads[i] = cand[i] && (t_type[i] == 1);
`ifdef MESI_ISC_BREQ_WR_PRIO_EN
        if (wr_heads != '0) cand = wr_heads;
`endif
        for (int k = 0; k < N; k++) begin
            if (cand[(p_m + k) % N]) return (p_m + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int c;
        int j;
        logic [N-1:0] accv;
        ack_exp_t ae;
        gnt_exp_t ge;
        rst = t_rst;
        fifo_status_empty_array_i = t_empty;
        fifo_status_full_array_i  = t_full;
        broad_fifo_status_full_i  = t_bfull;
        for (int i = 0; i < N; i++) begin
            mbus_cmd_array_i[i*CMDW +: CMDW]  = 3'(t_cmd[i]);
            broad_addr_array_i[i*AW +: AW]    = t_addr[i];
            broad_type_array_i[i*TW +: TW]    = 2'(t_type[i]);
            broad_id_array_i[i*IDW +: IDW]    = t_id[i];
        end
        c = cyc;
        if (t_rst) begin
            p_m = 0;
        end else if (!t_bfull) begin
            j = pick_channel();
            if (j >= 0) begin
                ge.cyc  = c;
                ge.rd   = 4'(1 << j);
                ge.cid  = 2'(j);
                ge.addr = t_addr[j];
                ge.typ  = 2'(t_type[j]);
                ge.id   = t_id[j];
                gntq.push_back(ge);
                p_m = (j + 1) % N;
            end
        end
        if (t_rst) begin
            ack_m = '0;
            for (int i = 0; i < N; i++) id_m[i] = i;
        end else begin
            accv = '0;
            for (int i = 0; i < N; i++)
                accv[i] = (t_cmd[i] == 3 || t_cmd[i] == 4) && !t_full[i] && !ack_m[i];
            if (accv != '0) begin
                ae.cyc = c + 1;
                ae.vec = accv;
                ae.typ = '0;
                ae.ids = '0;
                for (int i = 0; i < N; i++) begin
                    if (accv[i]) begin
                        ae.typ[i*TW +: TW]   = (t_cmd[i] == 4) ? 2'd2 : 2'd1;
                        ae.ids[i*IDW +: IDW] = 7'(id_m[i]);
                        id_m[i] = (id_m[i] + N) % 128;
                    end
                end
                ackq.push_back(ae);
            end
            ack_m = accv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        t_rst = 1'b0;
        t_full = '0;
        t_empty = '1;
        t_bfull = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_cmd[i]  = 0;
            t_addr[i] = $urandom;
            t_type[i] = $urandom_range(0, 2);
            t_id[i]   = 7'($urandom);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the head of each queue.
    ack_exp_t ma;
    gnt_exp_t mg;
    bit exp_a;
    bit exp_g;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_a = (ackq.size() > 0) && (ackq[0].cyc == cyc);
            check("ack_present", 64'(|mbus_ack_array_o), 64'(exp_a));
            check("fifo_wr_present", 64'(|fifo_wr_array_o), 64'(exp_a));
            if (exp_a) begin
                ma = ackq.pop_front();
                check("ack_vec", 64'(mbus_ack_array_o), 64'(ma.vec));
                check("fifo_wr_vec", 64'(fifo_wr_array_o), 64'(ma.vec));
                for (int i = 0; i < N; i++) begin
                    if (ma.vec[i]) begin
                        check("breq_type", 64'(breq_type_array_o[i*TW +: TW]), 64'(ma.typ[i*TW +: TW]));
                        check("breq_id", 64'(breq_id_array_o[i*IDW +: IDW]), 64'(ma.ids[i*IDW +: IDW]));
                    end
                end
            end
            exp_g = (gntq.size() > 0) && (gntq[0].cyc == cyc);
            check("grant_present", 64'(broad_fifo_wr_o), 64'(exp_g));
            check("rd_onehot0", 64'($onehot0(fifo_rd_array_o)), 64'd1);
            check("bwr_eq_or_rd", 64'(broad_fifo_wr_o), 64'(|fifo_rd_array_o));
            if (exp_g) begin
                mg = gntq.pop_front();
                check("fifo_rd", 64'(fifo_rd_array_o), 64'(mg.rd));
                check("broad_cpu_id", 64'(broad_cpu_id_o), 64'(mg.cid));
                check("broad_addr", 64'(broad_addr_o), 64'(mg.addr));
                check("broad_type", 64'(broad_type_o), 64'(mg.typ));
                check("broad_id", 64'(broad_id_o), 64'(mg.id));
            end else begin
                check("idle_fifo_rd", 64'(fifo_rd_array_o), 64'd0);
                check("idle_mux", {21'd0, broad_addr_o, broad_type_o, broad_id_o, broad_cpu_id_o}, 64'd0);
            end
        end
    end

    initial begin
        idle_inputs();
        // reset with all channels non-empty: grants must stay forced off
        t_rst = 1'b1;
        t_empty = '0;
        step();
        mon_en = 1'b1;
        step();
        check("rst_ack", 64'(mbus_ack_array_o), 64'd0);
        check("rst_fifo_wr", 64'(fifo_wr_array_o), 64'd0);
        check("rst_breq_type", 64'(breq_type_array_o), 64'd0);
        check("rst_breq_id", 64'(breq_id_array_o), {36'd0, 7'd3, 7'd2, 7'd1, 7'd0});
        check("breq_cpu_id", 64'(breq_cpu_id_array_o), 64'h00e4);
        check("rst_fifo_rd", 64'(fifo_rd_array_o), 64'd0);
        check("rst_broad_wr", 64'(broad_fifo_wr_o), 64'd0);

        // single RD_BROAD on channel 2, then quiet
        idle_inputs();
        t_cmd[2] = 4;
        step();
        t_cmd[2] = 0;
        step();
        step();

        // 32 held WR_BROAD writes on channel 1 wrap its id back to 1
        t_cmd[1] = 3;
        repeat (64) step();
        t_cmd[1] = 0;
        check("id_wrap_ch1", 64'(breq_id_array_o[1*IDW +: IDW]), 64'd1);
        step();

        // all four channels non-empty: 0001,0010,0100,1000,0001
        t_empty = '0;
        repeat (5) step();

        // broadcast FIFO full blocks everything, pointer held
        t_bfull = 1'b1;
        repeat (3) step();
        t_bfull = 1'b0;
        repeat (2) step();

        // full[i] blocks ack indefinitely
        idle_inputs();
        t_cmd[0] = 4;
        t_full[0] = 1'b1;
        repeat (4) step();
        t_full[0] = 1'b0;
        repeat (3) step();

        // reset one cycle after an accept drops the pending ack
        idle_inputs();
        t_cmd[3] = 4;
        step();
        t_cmd[3] = 0;
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        check("rst_mid_ack", 64'(mbus_ack_array_o), 64'd0);
        check("rst_mid_id3", 64'(breq_id_array_o[3*IDW +: IDW]), 64'd3);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            t_rst   = ($urandom_range(0, 149) == 0);
            t_bfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                t_cmd[i]   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 4);
                t_full[i]  = ($urandom_range(0, 3) == 0);
                t_empty[i] = ($urandom_range(0, 2) == 0);
                t_addr[i]  = $urandom;
                t_type[i]  = $urandom_range(0, 2);
                t_id[i]    = 7'($urandom);
            end
            step();
        end

        // drain
        idle_inputs();
        repeat (4) step();
        check("ackq_drained", 64'(ackq.size()), 64'd0);
        check("gntq_drained", 64'(gntq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mesi_isc_breq_fifos_cntl_n.md
MESI_ISC_BREQ_FIFOS_CNTL_N -- requirements
Module: mesi_isc_breq_fifos_cntl_n

Interface
REQ-001 SHALL have parameter CPU_NUM, default 4, number of CPU channels (legal 2..8).
REQ-002 SHALL have parameter MBUS_CMD_WIDTH, default 3, main-bus command width per channel.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, broadcast address width.
REQ-004 SHALL have parameter BROAD_TYPE_WIDTH, default 2, broadcast type width.
REQ-005 SHALL have parameter BROAD_ID_WIDTH, default 7, broadcast id width.
REQ-006 SHALL have ports, one per line:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- mbus_cmd_array_i  in  CPU_NUM*MBUS_CMD_WIDTH  per-CPU main-bus command
- fifo_status_empty_array_i  in  CPU_NUM  per-channel breq FIFO empty
- fifo_status_full_array_i  in  CPU_NUM  per-channel breq FIFO full
- broad_fifo_status_full_i  in  1  broadcast FIFO full
- broad_addr_array_i  in  CPU_NUM*ADDR_WIDTH  breq FIFO head address (first-word-fall-through)
- broad_type_array_i  in  CPU_NUM*BROAD_TYPE_WIDTH  breq FIFO head type
- broad_id_array_i  in  CPU_NUM*BROAD_ID_WIDTH  breq FIFO head id
- mbus_ack_array_o  out  CPU_NUM  per-CPU command acknowledge
- fifo_wr_array_o  out  CPU_NUM  breq FIFO write strobe
- fifo_rd_array_o  out  CPU_NUM  breq FIFO pop strobe
- broad_fifo_wr_o  out  1  broadcast FIFO write strobe
- broad_addr_o / broad_type_o / broad_id_o  out  ADDR_WIDTH / BROAD_TYPE_WIDTH / BROAD_ID_WIDTH  selected head fields
- broad_cpu_id_o  out  $clog2(CPU_NUM)  granted channel index
- breq_type_array_o / breq_cpu_id_array_o / breq_id_array_o  out  per-channel packed  data written into breq FIFO i

Function
REQ-010 Command codes SHALL be NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4; breq types NOP=0, WR=1, RD=2; values 5-7 do not occur.
REQ-011 Channel i SHALL accept when cmd[i] in {WR_BROAD, RD_BROAD}, !full[i], and !mbus_ack[i]; next cycle mbus_ack[i]=1 and fifo_wr[i]=1 for exactly one cycle.
REQ-012 breq_type[i] SHALL be registered one cycle after cmd[i]: RD_BROAD->RD, WR_BROAD->WR, other->NOP.
REQ-013 breq_cpu_id[i] SHALL be constant i.
REQ-014 breq_id[i] SHALL advance by CPU_NUM on each fifo_wr[i], wrap modulo 2^BROAD_ID_WIDTH.
REQ-015 Held broadcast command with FIFO not full SHALL ack every second cycle; full[i]=1 SHALL block ack with no limit.
REQ-016 Arbiter: when !broad_fifo_status_full_i and any channel non-empty, SHALL assert fifo_rd[j] and broad_fifo_wr_o in the same cycle (combinational) for one granted j.
REQ-017 Grant SHALL be first non-empty channel from pointer p upward, wrapping; after grant p<=(j+1) mod CPU_NUM; no grant leaves p unchanged.
REQ-018 fifo_rd_array_o SHALL be onehot0; broad_fifo_wr_o == |fifo_rd_array_o.
REQ-019 broad_addr/type/id_o SHALL mux channel j fields; broad_cpu_id_o=j; when no grant, all zero.
REQ-020 Non-empty channel SHALL be granted within CPU_NUM cycles while broad FIFO stays not full (macro off).
REQ-021 Broad FIFO full SHALL block all grants; pointer held.

Reset
REQ-030 During rst: mbus_ack, fifo_wr, breq_type=0; breq_id[i]=i; p=0; fifo_rd and broad_fifo_wr forced 0.
REQ-031 rst asserted mid-transaction SHALL drop pending ack/write next edge; no partial outputs.

Configuration
REQ-040 MESI_ISC_BREQ_WR_PRIO_EN defined: arbiter SHALL grant round-robin among non-empty channels with head type WR first, else round-robin among all non-empty; REQ-020 bound applies to WR heads only.
REQ-041 Macro undefined: pure round-robin per REQ-017.

Structure
REQ-050 mesi_isc_pkg SHALL hold command/breq-type enums and width constants.
REQ-051 Sub-module mesi_isc_rr_arb SHALL implement N-way round-robin with request and priority-mask inputs.

Verification
REQ-060 cmd[2]=RD_BROAD, full[2]=0 -> next cycle ack[2]=1, fifo_wr[2]=1, breq_type[2]=2, breq_id[2]=2; following cycle ack[2]=0.
REQ-061 All 4 channels non-empty, broad not full, p=0 -> fifo_rd sequence 0001,0010,0100,1000,0001.
REQ-062 broad_full=1 with channels non-empty -> fifo_rd=0, broad_fifo_wr=0, p unchanged.
REQ-063 BROAD_ID_WIDTH=7, CPU_NUM=4, 32 writes on channel 1 -> breq_id[1] returns to 1.
REQ-064 Macro on, p=0, ch0 head RD, ch3 head WR -> grant ch3; macro off -> grant ch0.
REQ-065 rst pulsed one cycle after accept -> ack[i]=0, breq_id[i]=i next cycle.
